alu_issue: RTL and testbench
============================

# alu_issue

Operand-issue stage that sits directly upstream of the ALU. It holds the 8×16 general register file and the architectural flags register. It accepts one instruction per cycle under a valid/ready handshake and drives registered `Op1`/`Op2`/`AluOp`/`CarryIn` into the ALU. One cycle later it writes the ALU `Result` and `Flags` back, forwarding in-flight results so dependent back-to-back instructions issue without stalls.

## Interface
Parameters:
- `NREGS`, 8: register count; addresses are 3 bits, fixed.

Ports:
- `Clock`  in  1  sole clock; everything updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `InValid`  in  1  an instruction is presented this cycle.
- `InReady`  out  1  the stage accepts the instruction this cycle (combinational).
- `RaSel`, `RbSel`, `RdSel`  in  3 each  source A, source B and destination register.
- `ImmSel`  in  1  when 1, Op2 comes from `Imm` instead of `RbSel`.
- `Imm`  in  16  immediate operand.
- `AluOpIn`  in  `opcodes::alu_functions_t`  requested ALU function.
- `RegWe`, `FlagsWe`  in  1 each  the instruction writes Rd / writes the flags.
- `Stall`  in  1  downstream hold; freezes the EX latch.
- `ExtWe`  in  1, `ExtAddr`  in  3, `ExtData`  in  16  load-writeback port.
- `Op1`, `Op2`  out  16 each  registered ALU operands.
- `AluOp`  out  `alu_functions_t`  registered ALU function.
- `CarryIn`  out  1  registered carry for FnADC/FnSUC.
- `ExValid`  out  1  the EX latch holds a live instruction.
- `AluResult`  in  16, `AluFlags`  in  4  combinational ALU outputs for the op in EX.
- `Flags`  out  4  architectural flags; bit positions per `FLAGS_Z/N/C/V`.

## Operation
- Issue (accept) occurs when `InValid & InReady`.
- `InReady = ~Reset & ~Stall & ~ExtWe & ~hazard`.
  - `hazard` is always 0 when the bypass is compiled in.
- At the issue edge:
  - Op1 ← rd(RaSel).
  - Op2 ← ImmSel ? Imm : rd(RbSel).
  - AluOp ← AluOpIn.
  - CarryIn ← current C.
  - Latch RdSel, RegWe and FlagsWe; ExValid ← 1.
- `rd(x)` returns `AluResult` if `ExValid & RegWe_q & Rd_q==x`; otherwise R[x].
- "Current C" is `AluFlags[C]` if `ExValid & FlagsWe_q`; otherwise `Flags[C]`.
- Writeback happens on every edge where `ExValid & ~Stall`:
  - if RegWe_q: R[Rd_q] ← AluResult.
  - if FlagsWe_q: Flags ← AluFlags.
- On any non-stalled edge with no issue, the EX latch becomes a bubble: ExValid ← 0, AluOp ← FnNOP. Op1/Op2/CarryIn hold.
- During `Stall`, the EX latch and Flags hold, and no ALU writeback occurs.
- `ExtWe` writes R[ExtAddr] ← ExtData at the edge, including during `Stall`.
- If `ExtWe` and an ALU writeback hit the same register on the same edge, the ALU value wins.
- FnNOP with RegWe=0 and FlagsWe=0 is a legal no-op issue.

## Timing
- Reset values:
  - all R[i]=0, Flags=0.
  - Op1=Op2=0, AluOp=FnNOP, CarryIn=0, ExValid=0.
  - InReady=0 while Reset is high.
- Issue at edge N → operands are on the ALU during cycle N+1 → result is in the register file after edge N+1.
- A dependent instruction can issue at edge N+1 with zero bubbles (bypass).
- An ExtWe value is readable by an instruction issued at the following edge or later.
- Reset asserted mid-operation clears the EX latch immediately; the in-flight writeback is lost.
- Pipeline states: EMPTY (ExValid=0), BUSY (ExValid=1), HELD (ExValid=1 & Stall).
  - EMPTY→BUSY on issue.
  - BUSY→EMPTY on a non-stalled edge with no issue.
  - BUSY↔HELD follows Stall.

## Configuration
- `ALU_ISSUE_BYPASS_EN` defined:
  - forwarding from AluResult/AluFlags as described;
  - `hazard` is tied to 0.
- Not defined:
  - no forwarding; rd(x)=R[x] and carry comes from Flags only;
  - `hazard` = `ExValid & ((RegWe_q & (Rd_q==RaSel | (~ImmSel & Rd_q==RbSel))) | (FlagsWe_q & (AluOpIn==FnADC | AluOpIn==FnSUC)))`.
  - The hazard costs exactly one bubble.

## Test plan
- Reset check: assert Reset mid-issue → all outputs at their reset values immediately, InReady=0; after release, R[0..7] read 0.
- Immediate then dependent add: ADD R1←R0+Imm 0x0005 (FlagsWe=0), then ADD R2←R1+R1 on the next cycle.
  - Bypass build: Op1=Op2=0x0005 on the second issue, no bubble; R2=0x000A.
  - No-bypass build: one InReady=0 cycle.
- Carry chain: ADD R3←0xFFFF+Imm 0x0001 with FlagsWe=1, then ADC on the next cycle → CarryIn=1 for the ADC and R3=0x0000; Flags Z=1, C=1 after writeback.
- Stall: assert Stall for 3 cycles with ExValid=1 → Op1/Op2/AluOp stable, no register or Flags change, InReady=0; the write lands on the first edge after Stall drops.
- Write collision: ExtWe to R4=0x1234 on the same edge as ALU writeback R4=0x00FF → R4=0x00FF. ExtWe to R5 alone → R5=0x1234, readable on the next issue.
- Bubble: InValid=0 for one cycle after an issue → ExValid=0, AluOp=FnNOP, and Flags are unchanged.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: operand-issue stage ahead of the ALU (8x16 register file, flags, EX latch).
// Build option: define ALU_ISSUE_BYPASS_EN to forward in-flight results instead of taking one bubble.
package opcodes;
  typedef enum logic [3:0] {
    FnNOP = 4'd0,
    FnADD = 4'd1,
    FnADC = 4'd2,
    FnSUB = 4'd3,
    FnSUC = 4'd4,
    FnAND = 4'd5,
    FnOR  = 4'd6,
    FnXOR = 4'd7,
    FnMOV = 4'd8
  } alu_functions_t;

  localparam int FLAGS_Z = 0;
  localparam int FLAGS_N = 1;
  localparam int FLAGS_C = 2;
  localparam int FLAGS_V = 3;
endpackage

module alu_issue
  import opcodes::*;
#(
  parameter int NREGS = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           InValid,
  output logic           InReady,
  input  logic [2:0]     RaSel,
  input  logic [2:0]     RbSel,
  input  logic [2:0]     RdSel,
  input  logic           ImmSel,
  input  logic [15:0]    Imm,
  input  alu_functions_t AluOpIn,
  input  logic           RegWe,
  input  logic           FlagsWe,
  input  logic           Stall,
  input  logic           ExtWe,
  input  logic [2:0]     ExtAddr,
  input  logic [15:0]    ExtData,
  output logic [15:0]    Op1,
  output logic [15:0]    Op2,
  output alu_functions_t AluOp,
  output logic           CarryIn,
  output logic           ExValid,
  input  logic [15:0]    AluResult,
  input  logic [3:0]     AluFlags,
  output logic [3:0]     Flags
);

  logic [15:0]    rf_q [NREGS];
  logic [15:0]    rf_d [NREGS];
  logic [3:0]     flags_q, flags_d;

  // EX latch; pipeline state EMPTY: !exvalid_q | BUSY: exvalid_q | HELD: exvalid_q & Stall
  logic [15:0]    op1_q, op2_q;
  alu_functions_t aluop_q;
  logic           carry_q;
  logic           exvalid_q;
  logic [2:0]     rd_q;
  logic           regwe_q;
  logic           flagswe_q;

  logic [15:0]    rd_a, rd_b;
  logic           cur_c;
  logic           hazard;
  logic           issue;
  logic           wb;

`ifdef ALU_ISSUE_BYPASS_EN
  assign rd_a   = (exvalid_q && regwe_q && rd_q == RaSel) ? AluResult : rf_q[RaSel];
  assign rd_b   = (exvalid_q && regwe_q && rd_q == RbSel) ? AluResult : rf_q[RbSel];
  assign cur_c  = (exvalid_q && flagswe_q) ? AluFlags[FLAGS_C] : flags_q[FLAGS_C];
  assign hazard = 1'b0;
`else
  assign rd_a   = rf_q[RaSel];
  assign rd_b   = rf_q[RbSel];
  assign cur_c  = flags_q[FLAGS_C];
  assign hazard = exvalid_q &&
                  ((regwe_q && (rd_q == RaSel || (!ImmSel && rd_q == RbSel))) ||
                   (flagswe_q && (AluOpIn == FnADC || AluOpIn == FnSUC)));
`endif

  assign InReady = !Reset && !Stall && !ExtWe && !hazard;
  assign issue   = InValid && InReady;
  assign wb      = exvalid_q && !Stall;

  // ALU writeback is applied after ExtWe so it wins a same-register collision.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      rf_d[i] = rf_q[i];
      if (ExtWe && ExtAddr == 3'(i)) rf_d[i] = ExtData;
      if (wb && regwe_q && rd_q == 3'(i)) rf_d[i] = AluResult;
    end
  end

  assign flags_d = (wb && flagswe_q) ? AluFlags : flags_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      flags_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op1_q     <= '0;
      op2_q     <= '0;
      aluop_q   <= FnNOP;
      carry_q   <= 1'b0;
      exvalid_q <= 1'b0;
      rd_q      <= '0;
      regwe_q   <= 1'b0;
      flagswe_q <= 1'b0;
    end else if (!Stall) begin
      if (issue) begin
        op1_q     <= rd_a;
        op2_q     <= ImmSel ? Imm : rd_b;
        aluop_q   <= AluOpIn;
        carry_q   <= cur_c;
        exvalid_q <= 1'b1;
        rd_q      <= RdSel;
        regwe_q   <= RegWe;
        flagswe_q <= FlagsWe;
      end else begin
        exvalid_q <= 1'b0;
        aluop_q   <= FnNOP;
      end
    end
  end

  assign Op1     = op1_q;
  assign Op2     = op2_q;
  assign AluOp   = aluop_q;
  assign CarryIn = carry_q;
  assign ExValid = exvalid_q;
  assign Flags   = flags_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small add-family ALU model closing the loop.
module tb_alu_issue;
  import opcodes::*;

  logic           Clock = 1'b0;
  logic           Reset = 1'b1;
  logic           InValid = 1'b0;
  logic           InReady;
  logic [2:0]     RaSel = '0, RbSel = '0, RdSel = '0;
  logic           ImmSel = 1'b0;
  logic [15:0]    Imm = '0;
  alu_functions_t AluOpIn = FnNOP;
  logic           RegWe = 1'b0, FlagsWe = 1'b0;
  logic           Stall = 1'b0;
  logic           ExtWe = 1'b0;
  logic [2:0]     ExtAddr = '0;
  logic [15:0]    ExtData = '0;
  logic [15:0]    Op1, Op2;
  alu_functions_t AluOp;
  logic           CarryIn, ExValid;
  logic [15:0]    AluResult;
  logic [3:0]     AluFlags;
  logic [3:0]     Flags;

  int errors = 0;
  int checks = 0;

  alu_issue dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .RaSel(RaSel), .RbSel(RbSel), .RdSel(RdSel), .ImmSel(ImmSel), .Imm(Imm),
    .AluOpIn(AluOpIn), .RegWe(RegWe), .FlagsWe(FlagsWe), .Stall(Stall),
    .ExtWe(ExtWe), .ExtAddr(ExtAddr), .ExtData(ExtData),
    .Op1(Op1), .Op2(Op2), .AluOp(AluOp), .CarryIn(CarryIn), .ExValid(ExValid),
    .AluResult(AluResult), .AluFlags(AluFlags), .Flags(Flags)
  );

  always #5 Clock = ~Clock;

  // Add-family ALU; other functions are never written back in this bench.
  logic [16:0] alu_sum;
  logic [15:0] alu_b;
  logic        alu_cin;
  always_comb begin
    alu_b   = Op2;
    alu_cin = 1'b0;
    case (AluOp)
      FnADC:   alu_cin = CarryIn;
      FnSUB:   begin alu_b = ~Op2; alu_cin = 1'b1; end
      FnSUC:   begin alu_b = ~Op2; alu_cin = CarryIn; end
      default: ;
    endcase
    alu_sum   = {1'b0, Op1} + {1'b0, alu_b} + {16'b0, alu_cin};
    AluResult = alu_sum[15:0];
    AluFlags  = '0;
    AluFlags[FLAGS_Z] = (alu_sum[15:0] == 16'h0000);
    AluFlags[FLAGS_N] = alu_sum[15];
    AluFlags[FLAGS_C] = alu_sum[16];
    AluFlags[FLAGS_V] = (Op1[15] == alu_b[15]) && (alu_sum[15] != Op1[15]);
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    InValid = 1'b0; RegWe = 1'b0; FlagsWe = 1'b0; ImmSel = 1'b0;
    AluOpIn = FnNOP; ExtWe = 1'b0; Stall = 1'b0;
  endtask

  task automatic set_instr(input alu_functions_t op, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [2:0] rd, input logic immsel, input logic [15:0] imm,
                           input logic regwe, input logic flagswe);
    InValid = 1'b1; AluOpIn = op; RaSel = ra; RbSel = rb; RdSel = rd;
    ImmSel = immsel; Imm = imm; RegWe = regwe; FlagsWe = flagswe;
  endtask

  // Issues a no-op that reads idx on port A and returns the issued Op1.
  task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
    int k = 0;
    set_instr(FnNOP, idx, idx, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    while (!InReady && k < 4) begin
      step();
      k++;
    end
    checks++;
    if (!InReady) begin
      errors++;
      $display("FAIL read_timeout: InReady=%b want 1 (reading R%0d)", InReady, idx);
    end
    @(posedge Clock);
    #1;
    val = Op1;
    InValid = 1'b0;
  endtask

  task automatic test_reset();
    set_instr(FnADD, 3'd1, 3'd2, 3'd3, 1'b1, 16'h1111, 1'b1, 1'b1);
    step(); step();
    checks++; if (Op1 !== 16'h0000) begin errors++; $display("FAIL rst_op1: got %h want 0000", Op1); end
    checks++; if (Op2 !== 16'h0000) begin errors++; $display("FAIL rst_op2: got %h want 0000", Op2); end
    checks++; if (AluOp !== FnNOP) begin errors++; $display("FAIL rst_aluop: got %0d want %0d", AluOp, FnNOP); end
    checks++; if (CarryIn !== 1'b0) begin errors++; $display("FAIL rst_carry: got %b want 0", CarryIn); end
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL rst_exvalid: got %b want 0", ExValid); end
    checks++; if (Flags !== 4'h0) begin errors++; $display("FAIL rst_flags: got %h want 0", Flags); end
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL rst_inready: got %b want 0", InReady); end
    Reset = 1'b0;
    idle();
    step();
  endtask

  task automatic test_dep_add();
    logic [15:0] v;
    set_instr(FnADD, 3'd0, 3'd0, 3'd1, 1'b1, 16'h0005, 1'b1, 1'b0);
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL dep_ready1: got %b want 1", InReady); end
    step();
    checks++; if (Op1 !== 16'h0000) begin errors++; $display("FAIL dep_op1a: got %h want 0000", Op1); end
    checks++; if (Op2 !== 16'h0005) begin errors++; $display("FAIL dep_op2a: got %h want 0005", Op2); end
    checks++; if (AluOp !== FnADD) begin errors++; $display("FAIL dep_aluop: got %0d want %0d", AluOp, FnADD); end
    checks++; if (ExValid !== 1'b1) begin errors++; $display("FAIL dep_exvalid: got %b want 1", ExValid); end
    set_instr(FnADD, 3'd1, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b1, 1'b0);
    #1;
`ifdef ALU_ISSUE_BYPASS_EN
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL dep_bypass_ready: got %b want 1", InReady); end
    step();
`else
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL dep_hazard_ready: got %b want 0", InReady); end
    step();
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL dep_bubble: got %b want 0", ExValid); end
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL dep_ready2: got %b want 1", InReady); end
    step();
`endif
    checks++; if (Op1 !== 16'h0005) begin errors++; $display("FAIL dep_op1b: got %h want 0005", Op1); end
    checks++; if (Op2 !== 16'h0005) begin errors++; $display("FAIL dep_op2b: got %h want 0005", Op2); end
    idle();
    step();
    read_reg(3'd2, v);
    checks++; if (v !== 16'h000A) begin errors++; $display("FAIL dep_r2: got %h want 000a", v); end
  endtask

  task automatic test_carry_chain();
    logic [15:0] v;
    idle();
    ExtWe = 1'b1; ExtAddr = 3'd6; ExtData = 16'hFFFF;
    step();
    ExtWe = 1'b0;
    set_instr(FnADD, 3'd6, 3'd0, 3'd3, 1'b1, 16'h0001, 1'b1, 1'b1);
    step();
    checks++; if (Op1 !== 16'hFFFF) begin errors++; $display("FAIL cc_op1: got %h want ffff", Op1); end
    set_instr(FnADC, 3'd0, 3'd0, 3'd7, 1'b1, 16'h0000, 1'b1, 1'b1);
    #1;
`ifdef ALU_ISSUE_BYPASS_EN
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL cc_bypass_ready: got %b want 1", InReady); end
    step();
    checks++; if (Flags !== 4'b0101) begin errors++; $display("FAIL cc_flags_zc: got %b want 0101", Flags); end
`else
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL cc_hazard_ready: got %b want 0", InReady); end
    step();
    checks++; if (Flags !== 4'b0101) begin errors++; $display("FAIL cc_flags_zc: got %b want 0101", Flags); end
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL cc_bubble: got %b want 0", ExValid); end
    step();
`endif
    checks++; if (AluOp !== FnADC) begin errors++; $display("FAIL cc_aluop: got %0d want %0d", AluOp, FnADC); end
    checks++; if (CarryIn !== 1'b1) begin errors++; $display("FAIL cc_carryin: got %b want 1", CarryIn); end
    idle();
    step();
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL cc_flags_adc: got %b want 0000", Flags); end
    read_reg(3'd3, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL cc_r3: got %h want 0000", v); end
    read_reg(3'd7, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL cc_r7: got %h want 0001", v); end
  endtask

  task automatic test_stall();
    logic [15:0] v;
    set_instr(FnADD, 3'd6, 3'd0, 3'd4, 1'b1, 16'h0100, 1'b1, 1'b1);
    step();
    checks++; if (Op2 !== 16'h0100) begin errors++; $display("FAIL st_op2: got %h want 0100", Op2); end
    Stall = 1'b1;
    set_instr(FnADD, 3'd1, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL st_ready%0d: got %b want 0", k, InReady); end
      if (k == 2) begin ExtWe = 1'b1; ExtAddr = 3'd5; ExtData = 16'h1234; end
      step();
      checks++; if (Op1 !== 16'hFFFF || Op2 !== 16'h0100) begin errors++; $display("FAIL st_ops%0d: got %h/%h want ffff/0100", k, Op1, Op2); end
      checks++; if (AluOp !== FnADD || ExValid !== 1'b1) begin errors++; $display("FAIL st_ex%0d: got op=%0d v=%b want op=%0d v=1", k, AluOp, ExValid, FnADD); end
      checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL st_flags%0d: got %b want 0000", k, Flags); end
    end
    Stall = 1'b0; InValid = 1'b0;
    ExtWe = 1'b1; ExtAddr = 3'd4; ExtData = 16'h1234;
    step();
    ExtWe = 1'b0;
    checks++; if (Flags !== 4'b0100) begin errors++; $display("FAIL st_flags_wb: got %b want 0100", Flags); end
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL st_bubble: got %b want 0", ExValid); end
    read_reg(3'd5, v);
    checks++; if (v !== 16'h1234) begin errors++; $display("FAIL st_r5_ext: got %h want 1234", v); end
    read_reg(3'd4, v);
    checks++; if (v !== 16'h00FF) begin errors++; $display("FAIL st_r4_collision: got %h want 00ff", v); end
  endtask

  task automatic test_bubble();
    logic [15:0] v;
    set_instr(FnADD, 3'd6, 3'd0, 3'd1, 1'b1, 16'h0001, 1'b1, 1'b0);
    step();
    checks++; if (ExValid !== 1'b1) begin errors++; $display("FAIL bub_issue: got %b want 1", ExValid); end
    idle();
    step();
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL bub_exvalid: got %b want 0", ExValid); end
    checks++; if (AluOp !== FnNOP) begin errors++; $display("FAIL bub_aluop: got %0d want %0d", AluOp, FnNOP); end
    checks++; if (Flags !== 4'b0100) begin errors++; $display("FAIL bub_flags: got %b want 0100", Flags); end
    checks++; if (Op1 !== 16'hFFFF || Op2 !== 16'h0001) begin errors++; $display("FAIL bub_hold: got %h/%h want ffff/0001", Op1, Op2); end
    read_reg(3'd1, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL bub_r1: got %h want 0000", v); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    set_instr(FnADD, 3'd0, 3'd0, 3'd2, 1'b1, 16'h0007, 1'b1, 1'b1);
    step();
    checks++; if (Op2 !== 16'h0007) begin errors++; $display("FAIL rm_issue: got %h want 0007", Op2); end
    #2 Reset = 1'b1;
    #1;
    checks++; if (Op2 !== 16'h0000) begin errors++; $display("FAIL rm_op2: got %h want 0000", Op2); end
    checks++; if (AluOp !== FnNOP) begin errors++; $display("FAIL rm_aluop: got %0d want %0d", AluOp, FnNOP); end
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL rm_exvalid: got %b want 0", ExValid); end
    checks++; if (Flags !== 4'h0) begin errors++; $display("FAIL rm_flags: got %h want 0", Flags); end
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL rm_inready: got %b want 0", InReady); end
    @(posedge Clock);
    #1 Reset = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rm_r%0d: got %h want 0000", i, v); end
    end
  endtask

  initial begin
    test_reset();
    test_dep_add();
    test_carry_chain();
    test_stall();
    test_bubble();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
